hazard_stall_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage RV32 core; complements the EX/MEM forwarding path.

---
 rtl/riscv_pipe_pkg.sv | 14 +
 rtl/mdu_occupancy_counter.sv | 25 ++
 rtl/hazard_stall_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding, default MDU latencies and the
// architectural zero register.
package riscv_pipe_pkg;

    typedef enum logic {
        StRun     = 1'b0,
        StMduBusy = 1'b1
    } pipe_state_e;

    localparam int unsigned MUL_LAT_DEF = 3;
    localparam int unsigned DIV_LAT_DEF = 34;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

endpackage

// File: rtl/mdu_occupancy_counter.sv
// Six-bit down counter tracking how many more stall cycles a multi-cycle MDU op needs in Execute.
module mdu_occupancy_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [5:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 6'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 6'd1;
        end
    end

    assign zero = (cnt_q == 6'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and MUL/DIV occupancy of
// Execute, plus a saturating count of front-end stall cycles.
module hazard_stall_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MduStartE,
    input  logic             MduIsDivE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MduValidE,
    output logic             MduBusy,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [6:0] MulLatW = 7'(MUL_LAT);
    localparam logic [6:0] DivLatW = 7'(DIV_LAT);

    pipe_state_e state_q, state_d;
    logic        lw_stall;
    logic [6:0]  sel_lat;
    logic [5:0]  cnt_init;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] stall_count_q;

    assign lw_stall = LoadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign sel_lat  = MduIsDivE ? DivLatW : MulLatW;
    // The start cycle itself is the first stall, so the counter covers the remaining LAT-2.
    assign cnt_init = 6'(sel_lat - 7'd2);

    mdu_occupancy_counter u_occ (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_init),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MduValidE = 1'b0;
        MduBusy   = 1'b0;

        unique case (state_q)
            StRun: begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
                if (MduStartE) begin
                    if (sel_lat == 7'd1) begin
                        MduValidE = 1'b1;
                    end else begin
                        StallF   = 1'b1;
                        StallD   = 1'b1;
                        StallE   = 1'b1;
                        FlushM   = 1'b1;
                        FlushD   = 1'b0;
                        FlushE   = 1'b0;
                        cnt_load = 1'b1;
                        state_d  = StMduBusy;
                    end
                end
            end
            StMduBusy: begin
                MduBusy = 1'b1;
                if (!cnt_zero) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    FlushM  = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    MduValidE = 1'b1;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        // Outputs are squashed for the whole reset window, not just after the first edge.
        if (!rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
            MduValidE = 1'b0;
            MduBusy   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else if (StallF && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_count_q;

endmodule
